sipo_frame_ctrl: RTL and testbench

- Frame-level receive controller that sequences a serial-in/parallel-out shift path.
- Each frame is: start bit, N data bits (LSB first), optional parity bit, stop bit. Bits arrive qualified by an external bit strobe.
- Detects the start bit, counts data bits, checks parity and stop, and commits the assembled word to a registered output behind a valid/ready handshake.
- Sits between a bit-timing front end (which produces bit_stb) and a word-wide consumer.

---
 rtl/sipo_frame_pkg.sv | 7 +
 rtl/sipo_frame_shreg.sv | 19 +
 rtl/sipo_frame_ctrl.sv | 92 +++++++++
 tb/tb_sipo_frame_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_pkg.sv
// sipo_frame_pkg: shared FSM state type and counter-width helper for the SIPO frame receiver
package sipo_frame_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, STOP} state_t;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sipo_frame_shreg.sv
// sipo_frame_shreg: N-bit right-shift register, new bit enters the MSB, with clear and running XOR
// clk/rst: clock, sync active-low reset; clr: zero the register; shift/din: shift din in at the MSB
// q: parallel value; par: XOR over all bits of q
module sipo_frame_shreg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift,
  input  logic         din,
  output logic [N-1:0] q,
  output logic         par
);
  always_ff @(posedge clk)
    if (!rst || clr) q <= '0;
    else if (shift) q <= {din, q[N-1:1]};
  assign par = ^q;
endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frame receiver (start, N data bits LSB first, optional parity, stop) with valid/ready output
// clk/rst: clock, sync active-low reset; en: block enable; bit_stb/sin: strobed serial bit
// out_ready/out_valid/out_data/out_perr: output word handshake; frame_err/overrun: 1-cycle pulses; busy: not IDLE
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int N          = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bit_stb,
  input  logic         sin,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output logic         out_perr,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);
  localparam int CW = cnt_w(N);
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [N-1:0] sr;
  logic stb, par, perr, clr, shift, cap, commit, ferr, accept;
  assign stb = en & bit_stb;
  assign accept = !out_valid || out_ready;
  assign busy = state != IDLE;
  sipo_frame_shreg #(.N(N)) u_shreg (
    .clk(clk), .rst(rst), .clr(clr), .shift(shift), .din(sin), .q(sr), .par(par)
  );
  always_comb begin
    state_d = state;
    clr = 1'b0;
    shift = 1'b0;
    cap = 1'b0;
    commit = 1'b0;
    ferr = 1'b0;
    if (stb)
      case (state)
        IDLE: begin
          clr = !sin;
          state_d = sin ? IDLE : SHIFT;
        end
        SHIFT: begin
          shift = 1'b1;
          state_d = (cnt == CW'(N - 1)) ? ((PARITY_EN != 0) ? PAR : STOP) : SHIFT;
        end
        PAR: begin
          cap = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          commit = sin;
          ferr = !sin;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      perr <= 1'b0;
    end else begin
      state <= state_d;
      if (clr) cnt <= '0;
      else if (shift) cnt <= cnt + 1'b1;
      if (clr) perr <= 1'b0;
      else if (cap) perr <= par ^ sin ^ 1'(PARITY_ODD);
    end
  always_ff @(posedge clk)
    if (!rst) begin
      out_data <= '0;
      out_valid <= 1'b0;
      out_perr <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun <= commit & !accept;
      if (commit && accept) begin
        out_data <= sr;
        out_perr <= perr;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: directed self-checking bench for sipo_frame_ctrl (N=8, even parity)
module tb_sipo_frame_ctrl;
  logic clk = 0, rst = 0, en = 1, bit_stb = 0, sin = 1, out_ready = 0;
  logic [7:0] out_data;
  logic out_valid, out_perr, frame_err, overrun, busy;
  int tests = 0, fails = 0;
  logic mon = 0, low_seen = 0;
  sipo_frame_ctrl #(.N(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .en(en), .bit_stb(bit_stb), .sin(sin), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_perr(out_perr),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (mon && !out_valid) low_seen = 1;
  task automatic strobe(input logic b);
    bit_stb = 1;
    sin = b;
    @(posedge clk);
    #1;
    bit_stb = 0;
    sin = 1;
  endtask
  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    strobe(0);
    for (int i = 0; i < 8; i++) strobe(d[i]);
    strobe(p);
    strobe(s);
  endtask
  task automatic test_reset();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_data, out_valid, out_perr, frame_err, overrun, busy} !== 13'h0) begin
      fails++;
      $display("FAIL reset: outputs %h want 0", {out_data, out_valid, out_perr, frame_err, overrun, busy});
    end
    rst = 1;
  endtask
  task automatic test_frame_a5();
    out_ready = 1;
    send_frame(8'hA5, 0, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'hA5 || out_perr !== 0) begin
      fails++;
      $display("FAIL a5_commit: valid=%b data=%h perr=%b want 1 a5 0", out_valid, out_data, out_perr);
    end
    idle_cycle();
    tests++;
    if (out_valid !== 0) begin
      fails++;
      $display("FAIL a5_drain: valid=%b want 0", out_valid);
    end
  endtask
  task automatic test_parity_err();
    send_frame(8'hA5, 1, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'hA5 || out_perr !== 1 || frame_err !== 0) begin
      fails++;
      $display("FAIL perr: valid=%b data=%h perr=%b ferr=%b want 1 a5 1 0", out_valid, out_data, out_perr, frame_err);
    end
    idle_cycle();
  endtask
  task automatic test_stop_err();
    send_frame(8'h3C, 0, 0);
    tests++;
    if (frame_err !== 1 || out_valid !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL stop_err: ferr=%b valid=%b busy=%b want 1 0 0", frame_err, out_valid, busy);
    end
    idle_cycle();
    tests++;
    if (frame_err !== 0) begin
      fails++;
      $display("FAIL ferr_pulse: ferr=%b want 0", frame_err);
    end
  endtask
  task automatic test_overrun();
    out_ready = 0;
    send_frame(8'h11, 0, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'h11 || overrun !== 0) begin
      fails++;
      $display("FAIL ovr_first: valid=%b data=%h ovr=%b want 1 11 0", out_valid, out_data, overrun);
    end
    send_frame(8'h22, 0, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'h11 || overrun !== 1) begin
      fails++;
      $display("FAIL ovr_drop: valid=%b data=%h ovr=%b want 1 11 1", out_valid, out_data, overrun);
    end
    low_seen = 0;
    mon = 1;
    strobe(0);
    tests++;
    if (overrun !== 0) begin
      fails++;
      $display("FAIL ovr_pulse: ovr=%b want 0", overrun);
    end
    for (int i = 0; i < 8; i++) strobe(i == 0 || i == 1 || i == 4 || i == 5);
    strobe(0);
    out_ready = 1;
    strobe(1);
    mon = 0;
    tests++;
    if (out_valid !== 1 || out_data !== 8'h33 || overrun !== 0 || low_seen !== 0) begin
      fails++;
      $display("FAIL ovr_replace: valid=%b data=%h ovr=%b gap=%b want 1 33 0 0", out_valid, out_data, overrun, low_seen);
    end
    idle_cycle();
    tests++;
    if (out_valid !== 0) begin
      fails++;
      $display("FAIL ovr_drain: valid=%b want 0", out_valid);
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 0;
    send_frame(8'h77, 0, 1);
    strobe(0);
    for (int i = 0; i < 4; i++) strobe(1);
    tests++;
    if (busy !== 1 || out_valid !== 1) begin
      fails++;
      $display("FAIL pre_reset: busy=%b valid=%b want 1 1", busy, out_valid);
    end
    rst = 0;
    idle_cycle();
    tests++;
    if ({out_data, out_valid, out_perr, frame_err, overrun, busy} !== 13'h0) begin
      fails++;
      $display("FAIL mid_reset: outputs %h want 0", {out_data, out_valid, out_perr, frame_err, overrun, busy});
    end
    rst = 1;
    send_frame(8'h5A, 0, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'h5A || out_perr !== 0 || frame_err !== 0) begin
      fails++;
      $display("FAIL post_reset: valid=%b data=%h perr=%b ferr=%b want 1 5a 0 0", out_valid, out_data, out_perr, frame_err);
    end
    out_ready = 1;
    idle_cycle();
  endtask
  task automatic test_enable();
    logic [7:0] d = 8'hC3;
    strobe(0);
    for (int i = 0; i < 4; i++) strobe(d[i]);
    en = 0;
    for (int i = 0; i < 5; i++) strobe(i[0]);
    tests++;
    if (busy !== 1 || out_valid !== 0) begin
      fails++;
      $display("FAIL en_hold: busy=%b valid=%b want 1 0", busy, out_valid);
    end
    en = 1;
    for (int i = 4; i < 8; i++) strobe(d[i]);
    strobe(0);
    strobe(1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'hC3 || out_perr !== 0 || frame_err !== 0) begin
      fails++;
      $display("FAIL en_resume: valid=%b data=%h perr=%b ferr=%b want 1 c3 0 0", out_valid, out_data, out_perr, frame_err);
    end
  endtask
  task automatic test_back_to_back();
    send_frame(8'h81, 0, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'h81) begin
      fails++;
      $display("FAIL b2b_first: valid=%b data=%h want 1 81", out_valid, out_data);
    end
    send_frame(8'h07, 1, 1);
    tests++;
    if (out_valid !== 1 || out_data !== 8'h07 || out_perr !== 0 || busy !== 0) begin
      fails++;
      $display("FAIL b2b_second: valid=%b data=%h perr=%b busy=%b want 1 07 0 0", out_valid, out_data, out_perr, busy);
    end
    idle_cycle();
  endtask
  initial begin
    test_reset();
    test_frame_a5();
    test_parity_err();
    test_stop_err();
    test_overrun();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
